// File: rtl/kc_pkg.sv
// Shared types and constants for the KCC tape loader: FSM states and header field offsets.
package kc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_HEADER,
        ST_DATA,
        ST_WRITE,
        ST_FINISH,
        ST_ERR
    } state_t;

    localparam int HDR_LEN_DEF = 128;

    localparam int OFS_ARGS  = 16;
    localparam int OFS_LOAD  = 17;
    localparam int OFS_END   = 19;
    localparam int OFS_START = 21;

    // Bytes 16..22 are the only header bytes the loader cares about.
    localparam int HDR_FIELDS = OFS_START + 2 - OFS_ARGS;

endpackage

// File: rtl/kcc_hdr_parse.sv
// Captures the KCC header fields (args, load, end, start) from the ioctl byte stream
// and validates them when the last header byte arrives.
module kcc_hdr_parse
    import kc_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture,
    input  logic        check,
    input  logic [24:0] addr,
    input  logic [7:0]  data,
    output logic        hdr_good,
    output logic        hdr_valid,
    output logic [7:0]  args,
    output logic [15:0] load_addr,
    output logic [15:0] end_addr,
    output logic [15:0] start_addr
);

    logic [HDR_FIELDS-1:0][7:0] field;
    logic                       hdr_valid_reg;

    for (genvar gi = 0; gi < HDR_FIELDS; gi++) begin : g_field
        logic [7:0] byte_reg;

        always_ff @(posedge clk_sys) begin
            if (reset || clear) begin
                byte_reg <= 8'h00;
            end else if (capture && addr == 25'(OFS_ARGS + gi)) begin
                byte_reg <= data;
            end
        end

        assign field[gi] = byte_reg;
    end

    assign args       = field[0];
    assign load_addr  = {field[OFS_LOAD  - OFS_ARGS + 1], field[OFS_LOAD  - OFS_ARGS]};
    assign end_addr   = {field[OFS_END   - OFS_ARGS + 1], field[OFS_END   - OFS_ARGS]};
    assign start_addr = {field[OFS_START - OFS_ARGS + 1], field[OFS_START - OFS_ARGS]};

    // End address is exclusive, so an empty range is rejected as well.
    assign hdr_good = (args >= 8'd2) && (end_addr > load_addr);

    always_ff @(posedge clk_sys) begin
        if (reset || clear) begin
            hdr_valid_reg <= 1'b0;
        end else if (check && hdr_good) begin
            hdr_valid_reg <= 1'b1;
        end
    end

    assign hdr_valid = hdr_valid_reg;

endmodule

// File: rtl/kcc_tape_loader.sv
// Streams a KCC tape image from the HPS ioctl download into KC85/4 RAM while the Z80
// is held off the bus, and reports the autostart entry point when the load completes.
module kcc_tape_loader
    import kc_pkg::*;
#(
    parameter int HDR_LEN     = HDR_LEN_DEF,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        cpu_busrq,
    input  logic        cpu_busak,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        load_done,
    output logic        autostart,
    output logic [15:0] start_addr,
    output logic        load_err,
    output logic        busy
);

    localparam int                TMR_W    = $clog2(ACK_TIMEOUT + 2);
    localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(ACK_TIMEOUT);
    localparam logic [24:0]       LAST_HDR = 25'(HDR_LEN - 1);

    state_t             state_reg;
    logic               dl_prev_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic [15:0]        cur_addr_reg;
    logic               wait_reg;
    logic               busrq_reg;
    logic               mem_req_reg;
    logic [15:0]        mem_addr_reg;
    logic [7:0]         mem_data_reg;
    logic               load_done_reg;
    logic               autostart_reg;
    logic [15:0]        start_addr_reg;
    logic               load_err_reg;
    logic               busy_reg;

    logic               dl_rise;
    logic               hdr_capture;
    logic               hdr_check;
    logic               hdr_clear;
    logic               hdr_good;
    logic               hdr_valid;
    logic [7:0]         hdr_args;
    logic [15:0]        hdr_load;
    logic [15:0]        hdr_end;
    logic [15:0]        hdr_start;

    assign dl_rise     = ioctl_download && !dl_prev_reg;
    assign hdr_clear   = (state_reg == ST_IDLE) && dl_rise;
    assign hdr_capture = ioctl_wr && (state_reg == ST_HEADER);
    assign hdr_check   = hdr_capture && (ioctl_addr == LAST_HDR);

    kcc_hdr_parse u_hdr_parse (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .clear      (hdr_clear),
        .capture    (hdr_capture),
        .check      (hdr_check),
        .addr       (ioctl_addr),
        .data       (ioctl_dout),
        .hdr_good   (hdr_good),
        .hdr_valid  (hdr_valid),
        .args       (hdr_args),
        .load_addr  (hdr_load),
        .end_addr   (hdr_end),
        .start_addr (hdr_start)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            dl_prev_reg    <= 1'b0;
            timer_reg      <= '0;
            cur_addr_reg   <= 16'h0000;
            wait_reg       <= 1'b0;
            busrq_reg      <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= 16'h0000;
            mem_data_reg   <= 8'h00;
            load_done_reg  <= 1'b0;
            autostart_reg  <= 1'b0;
            start_addr_reg <= 16'h0000;
            load_err_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            dl_prev_reg   <= ioctl_download;
            load_done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (dl_rise) begin
                        load_err_reg <= 1'b0;
                        busrq_reg    <= 1'b1;
                        wait_reg     <= 1'b1;
                        busy_reg     <= 1'b1;
                        timer_reg    <= '0;
                        state_reg    <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (cpu_busak) begin
                        wait_reg  <= 1'b0;
                        state_reg <= ST_HEADER;
                    end else if (!ioctl_download || timer_reg > TMR_MAX) begin
                        state_reg <= ST_ERR;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                ST_HEADER: begin
                    // A byte arriving with the download fall is handled before the fall.
                    if (hdr_check) begin
                        if (hdr_good) begin
                            cur_addr_reg <= hdr_load;
                            state_reg    <= ioctl_download ? ST_DATA : ST_FINISH;
                        end else begin
                            state_reg <= ST_ERR;
                        end
                    end else if (!ioctl_download) begin
                        state_reg <= ST_ERR;
                    end
                end

                ST_DATA: begin
                    if (ioctl_wr && cur_addr_reg < hdr_end) begin
                        mem_addr_reg <= cur_addr_reg;
                        mem_data_reg <= ioctl_dout;
                        mem_req_reg  <= 1'b1;
                        wait_reg     <= 1'b1;
                        timer_reg    <= '0;
                        state_reg    <= ST_WRITE;
                    end else if (!ioctl_download) begin
                        state_reg <= ST_FINISH;
                    end
                end

                ST_WRITE: begin
                    if (mem_ack) begin
                        mem_req_reg  <= 1'b0;
                        cur_addr_reg <= cur_addr_reg + 16'd1;
                        wait_reg     <= 1'b0;
                        state_reg    <= ioctl_download ? ST_DATA : ST_FINISH;
                    end else if (timer_reg > TMR_MAX) begin
                        state_reg <= ST_ERR;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                ST_FINISH: begin
                    busrq_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    if (hdr_valid) begin
                        load_done_reg  <= 1'b1;
                        start_addr_reg <= hdr_start;
                        autostart_reg  <= (hdr_args >= 8'd3);
                    end
                    state_reg <= ST_IDLE;
                end

                ST_ERR: begin
                    // Remaining ioctl_wr strobes fall through here unused.
                    load_err_reg <= 1'b1;
                    busrq_reg    <= 1'b0;
                    wait_reg     <= 1'b0;
                    mem_req_reg  <= 1'b0;
                    busy_reg     <= 1'b0;
                    if (!ioctl_download) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Bus request is released in the same cycle reset is raised.
    assign cpu_busrq  = busrq_reg && !reset;
    assign ioctl_wait = wait_reg;
    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_data   = mem_data_reg;
    assign load_done  = load_done_reg;
    assign autostart  = autostart_reg;
    assign start_addr = start_addr_reg;
    assign load_err   = load_err_reg;
    assign busy       = busy_reg;

endmodule

// File: doc/kcc_tape_loader.md
Name: kcc_tape_loader

Overview:
- Sequences a KCC tape image, streamed from the OSD "Load Tape" file entry over the HPS ioctl download interface, into KC85/4 main RAM.
- Parses the 128-byte KCC header, holds the Z80 off the bus via BUSRQ/BUSAK, and writes payload bytes to RAM through a request/acknowledge port.
- Reports the autostart address to the top level.
- Sits between hps_io and the kc854 memory arbiter, in the clk_sys domain.

Parameters:
- HDR_LEN, 128, KCC header length in bytes; payload starts at ioctl_addr == HDR_LEN.
- ACK_TIMEOUT, 1023, maximum clk_sys cycles to wait for cpu_busak or mem_ack before ERR.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  high for the duration of a file transfer
- ioctl_wr  in  1  one-cycle strobe, byte valid
- ioctl_addr  in  25  byte offset in file
- ioctl_dout  in  8  file byte
- ioctl_wait  out  1  stalls HPS; no ioctl_wr is issued while high
- cpu_busrq  out  1  request Z80 bus release
- cpu_busak  in  1  Z80 has released the bus
- mem_req  out  1  RAM write request, held until acked
- mem_ack  in  1  one-cycle write-complete strobe
- mem_addr  out  16  RAM write address
- mem_data  out  8  RAM write data
- load_done  out  1  one-cycle pulse on successful completion
- autostart  out  1  level: the header holds a valid start address (arg count ≥3)
- start_addr  out  16  autostart entry point
- load_err  out  1  sticky error flag; cleared by reset or the next download start
- busy  out  1  high from download start to DONE/ERR, for LED_DISK

Behaviour:
- Reset values: all outputs 0; state IDLE; header registers 0.
- Header byte fields are little-endian:
  - byte 16: arg count
  - bytes 17-18: load address
  - bytes 19-20: end address (exclusive)
  - bytes 21-22: start address
  - all other header bytes are ignored.
- FSM states: IDLE, HOLD, HEADER, DATA, WRITE, FINISH, ERR.
- IDLE:
  - On the rising edge of ioctl_download, clear load_err, assert cpu_busrq and ioctl_wait, go to HOLD.
- HOLD:
  - Wait for cpu_busak. When it arrives, drop ioctl_wait and go to HEADER.
  - Timeout counter > ACK_TIMEOUT: go to ERR.
- HEADER:
  - Latch bytes on ioctl_wr at offsets 16..22.
  - On the write with ioctl_addr == HDR_LEN-1, validate the header:
    - arg count ≥2 and end > load: set cur_addr = load, go to DATA.
    - otherwise: go to ERR.
- DATA:
  - On ioctl_wr, ignore the byte if cur_addr ≥ end (padding in the final 128-byte block).
  - Otherwise: register mem_addr = cur_addr and mem_data = ioctl_dout, assert mem_req and ioctl_wait in the next cycle, go to WRITE.
  - If ioctl_download falls, go to FINISH.
- WRITE:
  - Hold mem_req, mem_addr and mem_data stable until mem_ack.
  - On mem_ack: drop mem_req, increment cur_addr (16-bit; wrap at FFFF→0000 is never reached because cur_addr < end ≤ FFFF), drop ioctl_wait, return to DATA.
  - Timeout counter > ACK_TIMEOUT: go to ERR.
  - Latency: mem_req rises 1 cycle after ioctl_wr; ioctl_wait falls 1 cycle after mem_ack.
- FINISH:
  - Release cpu_busrq.
  - If the header was validated, pulse load_done for one cycle and latch start_addr; set autostart if arg count ≥3.
  - Go to IDLE.
- ERR:
  - Set load_err, release cpu_busrq, drop ioctl_wait and mem_req.
  - Consume the remaining ioctl_wr strobes without writing.
  - Go to IDLE when ioctl_download is low.
- Download ends early (file shorter than header, i.e. ioctl_download falls while in HEADER): go to ERR.
- Download ends early while in WRITE: complete the pending write first, then go to FINISH.
- Data shorter than end-load: the payload is a partial load; load_done is still pulsed, with no error.
- reset mid-operation: return to IDLE next cycle with all outputs 0. cpu_busrq drops immediately. The interrupted RAM contents are undefined.
- ioctl_wr arriving together with ioctl_download falling: the byte is processed, then the fall is acted on.

Decomposition:
- Shared package kc_pkg:
  - FSM state enum
  - KCC header offset constants (OFS_ARGS=16, OFS_LOAD=17, OFS_END=19, OFS_START=21)
  - HDR_LEN default
- One natural sub-module: kcc_hdr_parse, covering header byte capture and validation, with outputs hdr_valid, load, end, start and args.

Test Plan:
1. Header args=3, load=0x0300, end=0x0305, start=0x0300, then 5 data bytes AA..EE, with busak after 4 cycles → mem writes 0300=AA…0304=EE; load_done pulses once; autostart=1; start_addr=0x0300.
2. Same file padded to 256 bytes → exactly 5 mem_req; padding ignored; no error.
3. end ≤ load (0x0400/0x0400) → load_err=1; no mem_req; cpu_busrq released.
4. cpu_busak never asserted → load_err=1 after ACK_TIMEOUT+1 cycles; ioctl_wait dropped.
5. mem_ack delayed 20 cycles per byte → ioctl_wait stays high throughout; no byte lost; addresses monotonic.
6. reset asserted during the WRITE state → next cycle all outputs 0; a following clean download succeeds.
